// File: rtl/eeg_oram_bank_ctrl.sv
// eeg_oram_bank_ctrl
//   Per-bank controller sitting behind the ORAM demux. Arbitrates the
//   bank-local write stream against the read-address stream onto one
//   single-port SRAM (one access per cycle), tracks the 1-cycle SRAM read
//   latency and buffers returned words so rd_rdy back-pressure never drops
//   data.
//
// Optional build macro: ORAM_BANK_STAT_EN adds per-frame beat counters
//   stat_wr_cnt / stat_rd_cnt (saturating, cleared the cycle after the
//   matching done pulse).
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   wr_vld/wr_lst/wr_add/wr_dat   write request stream, wr_rdy = accepted
//   ra_vld/ra_lst/ra_add          read-address stream, ra_rdy = accepted
//   rd_vld/rd_lst/rd_dat, rd_rdy  read-data return stream
//   sram_ce/we/add/wdat, rdat     single-port SRAM macro interface
//   wr_done, rd_done              1-cycle frame-complete pulses
//   stat_wr_cnt, stat_rd_cnt      (ORAM_BANK_STAT_EN only) beat counters
module eeg_oram_bank_ctrl #(
  parameter int ORAM_ADD_MW  = 10,
  parameter int ORAM_DAT_DW  = 4,
  parameter int RD_BUF_DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_vld,
  input  logic                   wr_lst,
  output logic                   wr_rdy,
  input  logic [ORAM_ADD_MW-1:0] wr_add,
  input  logic [ORAM_DAT_DW-1:0] wr_dat,
  input  logic                   ra_vld,
  input  logic                   ra_lst,
  output logic                   ra_rdy,
  input  logic [ORAM_ADD_MW-1:0] ra_add,
  output logic                   rd_vld,
  output logic                   rd_lst,
  input  logic                   rd_rdy,
  output logic [ORAM_DAT_DW-1:0] rd_dat,
  output logic                   sram_ce,
  output logic                   sram_we,
  output logic [ORAM_ADD_MW-1:0] sram_add,
  output logic [ORAM_DAT_DW-1:0] sram_wdat,
  input  logic [ORAM_DAT_DW-1:0] sram_rdat,
  output logic                   wr_done,
  output logic                   rd_done
`ifdef ORAM_BANK_STAT_EN
  ,
  output logic [15:0]            stat_wr_cnt,
  output logic [15:0]            stat_rd_cnt
`endif
);

  localparam int PW = (RD_BUF_DEPTH > 1) ? $clog2(RD_BUF_DEPTH) : 1;
  localparam int CW = PW + 1;

  localparam logic ARB_WR = 1'b0;

  // Buffer entry: {last flag, data}
  logic [ORAM_DAT_DW:0]   buf_mem [RD_BUF_DEPTH];
  logic [PW-1:0]          buf_wp;
  logic [PW-1:0]          buf_rp;
  logic [CW-1:0]          buf_count;
  logic                   inflight;
  logic                   lst_q;
  logic                   arb_ptr;
  logic [ORAM_ADD_MW-1:0] add_q;
  logic [ORAM_DAT_DW-1:0] wdat_q;

  logic          push;
  logic          pop;
  logic [CW-1:0] credit_used;
  logic          ra_ok;
  logic          wr_elig;
  logic          rd_elig;
  logic          contested;
  logic          wr_gnt;
  logic          rd_gnt;

  // Credit counts the slot freed by this cycle's pop: a read issued now
  // pushes next cycle, after the pop has taken effect. Without that term a
  // 2-entry buffer could not sustain one read per cycle.
  always_comb begin
    push        = inflight;
    pop         = (buf_count != '0) && rd_rdy;
    credit_used = buf_count + CW'(inflight) - CW'(pop);
    ra_ok       = credit_used < CW'(RD_BUF_DEPTH);
  end

  always_comb begin
    wr_elig   = wr_vld && !rst;
    rd_elig   = ra_vld && ra_ok && !rst;
    contested = wr_elig && rd_elig;
    wr_gnt    = wr_elig && (!rd_elig || (arb_ptr == ARB_WR));
    rd_gnt    = rd_elig && (!wr_elig || (arb_ptr != ARB_WR));
  end

  always_comb begin
    wr_rdy    = wr_gnt;
    ra_rdy    = rd_gnt;
    sram_ce   = wr_gnt || rd_gnt;
    sram_we   = wr_gnt;
    sram_add  = add_q;
    sram_wdat = wdat_q;
    if (wr_gnt) begin
      sram_add  = wr_add;
      sram_wdat = wr_dat;
    end else if (rd_gnt) begin
      sram_add  = ra_add;
    end
  end

  always_comb begin
    rd_vld = (buf_count != '0);
    rd_dat = buf_mem[buf_rp][ORAM_DAT_DW-1:0];
    rd_lst = buf_mem[buf_rp][ORAM_DAT_DW];
  end

  // Arbiter pointer and SRAM address/data hold registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arb_ptr <= ARB_WR;
      add_q   <= '0;
      wdat_q  <= '0;
    end else begin
      if (contested) arb_ptr <= ~arb_ptr;
      if (sram_ce)   add_q   <= sram_add;
      if (wr_gnt)    wdat_q  <= wr_dat;
    end
  end

  // Read-latency tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight <= 1'b0;
      lst_q    <= 1'b0;
    end else begin
      inflight <= rd_gnt;
      if (rd_gnt) lst_q <= ra_lst;
    end
  end

  // Read-return FIFO
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < RD_BUF_DEPTH; i++) buf_mem[i] <= '0;
      buf_wp    <= '0;
      buf_rp    <= '0;
      buf_count <= '0;
    end else begin
      if (push) begin
        buf_mem[buf_wp] <= {lst_q, sram_rdat};
        buf_wp          <= buf_wp + PW'(1);
      end
      if (pop) buf_rp <= buf_rp + PW'(1);
      case ({push, pop})
        2'b10:   buf_count <= buf_count + CW'(1);
        2'b01:   buf_count <= buf_count - CW'(1);
        default: buf_count <= buf_count;
      endcase
    end
  end

  // Frame-complete pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_done <= 1'b0;
      rd_done <= 1'b0;
    end else begin
      wr_done <= wr_gnt && wr_lst;
      rd_done <= pop && rd_lst;
    end
  end

`ifdef ORAM_BANK_STAT_EN
  // A beat accepted in the clearing cycle belongs to the new frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_wr_cnt <= '0;
      stat_rd_cnt <= '0;
    end else begin
      if (wr_done)
        stat_wr_cnt <= wr_gnt ? 16'd1 : 16'd0;
      else if (wr_gnt && (stat_wr_cnt != '1))
        stat_wr_cnt <= stat_wr_cnt + 16'd1;

      if (rd_done)
        stat_rd_cnt <= pop ? 16'd1 : 16'd0;
      else if (pop && (stat_rd_cnt != '1))
        stat_rd_cnt <= stat_rd_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_eeg_oram_bank_ctrl.sv
// Directed bench for eeg_oram_bank_ctrl: table of per-cycle vectors with
// hand-computed expectations, plus a mid-operation reset sequence.
module tb_eeg_oram_bank_ctrl;

  localparam int AW = 10;
  localparam int DW = 4;
  localparam int BD = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_vld, wr_lst, wr_rdy;
  logic [AW-1:0] wr_add;
  logic [DW-1:0] wr_dat;
  logic          ra_vld, ra_lst, ra_rdy;
  logic [AW-1:0] ra_add;
  logic          rd_vld, rd_lst, rd_rdy;
  logic [DW-1:0] rd_dat;
  logic          sram_ce, sram_we;
  logic [AW-1:0] sram_add;
  logic [DW-1:0] sram_wdat;
  logic [DW-1:0] sram_rdat;
  logic          wr_done, rd_done;

  eeg_oram_bank_ctrl #(
    .ORAM_ADD_MW (AW),
    .ORAM_DAT_DW (DW),
    .RD_BUF_DEPTH(BD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_vld   (wr_vld),
    .wr_lst   (wr_lst),
    .wr_rdy   (wr_rdy),
    .wr_add   (wr_add),
    .wr_dat   (wr_dat),
    .ra_vld   (ra_vld),
    .ra_lst   (ra_lst),
    .ra_rdy   (ra_rdy),
    .ra_add   (ra_add),
    .rd_vld   (rd_vld),
    .rd_lst   (rd_lst),
    .rd_rdy   (rd_rdy),
    .rd_dat   (rd_dat),
    .sram_ce  (sram_ce),
    .sram_we  (sram_we),
    .sram_add (sram_add),
    .sram_wdat(sram_wdat),
    .sram_rdat(sram_rdat),
    .wr_done  (wr_done),
    .rd_done  (rd_done)
  );

  always #5 clk = ~clk;

  // Behavioural single-port SRAM, 1-cycle read latency
  logic [DW-1:0] sram_mem [2**AW];
  always @(posedge clk) begin
    if (sram_ce) begin
      if (sram_we) sram_mem[sram_add] <= sram_wdat;
      else         sram_rdat <= sram_mem[sram_add];
    end
  end

  int n_cmp;
  int n_bad;

  typedef struct {
    logic          wv, wl;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          rv, rl;
    logic [AW-1:0] ra;
    logic          rr;
    logic          x_wrdy, x_rardy, x_ce, x_we;
    logic [AW-1:0] x_add;
    logic          x_rdv, x_rdl;
    logic [DW-1:0] x_rdd;
    logic          x_wdn, x_rdn;
  } vec_t;

  vec_t tbl[$];
  vec_t seq_pre[$];
  vec_t seq_post[$];

  function automatic vec_t mk(int wv, int wl, int wa, int wd, int rv, int rl, int ra, int rr,
                              int xw, int xr, int xce, int xwe, int xa,
                              int xv, int xl, int xd, int xwd, int xrd);
    vec_t v;
    v.wv = wv[0]; v.wl = wl[0]; v.wa = wa[AW-1:0]; v.wd = wd[DW-1:0];
    v.rv = rv[0]; v.rl = rl[0]; v.ra = ra[AW-1:0]; v.rr = rr[0];
    v.x_wrdy = xw[0]; v.x_rardy = xr[0]; v.x_ce = xce[0]; v.x_we = xwe[0];
    v.x_add = xa[AW-1:0];
    v.x_rdv = xv[0]; v.x_rdl = xl[0]; v.x_rdd = xd[DW-1:0];
    v.x_wdn = xwd[0]; v.x_rdn = xrd[0];
    return v;
  endfunction

  // idle input cycle with only the read-return expectations
  function automatic vec_t idle(int rr, int xv, int xl, int xd, int xwd, int xrd);
    return mk(0, 0, 0, 0, 0, 0, 0, rr, 0, 0, 0, 0, 0, xv, xl, xd, xwd, xrd);
  endfunction

  task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s row %0d: got %0h expected %0h", nm, row, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    wr_vld = v.wv; wr_lst = v.wl; wr_add = v.wa; wr_dat = v.wd;
    ra_vld = v.rv; ra_lst = v.rl; ra_add = v.ra; rd_rdy = v.rr;
  endtask

  task automatic check(input vec_t v, input int row);
    chk("wr_rdy", row, 32'(wr_rdy), 32'(v.x_wrdy));
    chk("ra_rdy", row, 32'(ra_rdy), 32'(v.x_rardy));
    chk("sram_ce", row, 32'(sram_ce), 32'(v.x_ce));
    if (v.x_ce) begin
      chk("sram_we", row, 32'(sram_we), 32'(v.x_we));
      chk("sram_add", row, 32'(sram_add), 32'(v.x_add));
      if (v.x_we) chk("sram_wdat", row, 32'(sram_wdat), 32'(v.wd));
    end
    chk("rd_vld", row, 32'(rd_vld), 32'(v.x_rdv));
    if (v.x_rdv) begin
      chk("rd_dat", row, 32'(rd_dat), 32'(v.x_rdd));
      chk("rd_lst", row, 32'(rd_lst), 32'(v.x_rdl));
    end
    chk("wr_done", row, 32'(wr_done), 32'(v.x_wdn));
    chk("rd_done", row, 32'(rd_done), 32'(v.x_rdn));
  endtask

  task automatic run(input vec_t q[$], input int base);
    foreach (q[i]) begin
      @(negedge clk);
      drive(q[i]);
      #1;
      check(q[i], base + i);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;

    // wv wl wa wd | rv rl ra | rr || wrdy rardy ce we add | rdv rdl rdd | wdn rdn
    // writes 0..7, data 1..8, last on 7
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(1, int'(i == 7), i, i + 1, 0, 0, 0, 1, 1, 0, 1, 1, i, 0, 0, 0, 0, 0));
    tbl.push_back(idle(1, 0, 0, 0, 1, 0));
    tbl.push_back(idle(1, 0, 0, 0, 0, 0));
    // reads 0..7, last on 7; first data two cycles after first accept
    for (int k = 0; k < 8; k++)
      tbl.push_back(mk(0, 0, 0, 0, 1, int'(k == 7), k, 1, 0, 1, 1, 0, k,
                       int'(k >= 2), 0, (k >= 2) ? k - 1 : 0, 0, 0));
    tbl.push_back(idle(1, 1, 0, 7, 0, 0));
    tbl.push_back(idle(1, 1, 1, 8, 0, 0));
    tbl.push_back(idle(1, 0, 0, 0, 0, 1));
    tbl.push_back(idle(1, 0, 0, 0, 0, 0));
    // contention: W,R,W,R,W,R with held beats
    tbl.push_back(mk(1, 0, 8, 9,   1, 0, 0, 1, 1, 0, 1, 1, 8,  0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 9, 10,  1, 0, 0, 1, 0, 1, 1, 0, 0,  0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 9, 10,  1, 0, 1, 1, 1, 0, 1, 1, 9,  0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 10, 11, 1, 0, 1, 1, 0, 1, 1, 0, 1,  1, 0, 1, 0, 0));
    tbl.push_back(mk(1, 0, 10, 11, 1, 0, 2, 1, 1, 0, 1, 1, 10, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 11, 12, 1, 0, 2, 1, 0, 1, 1, 0, 2,  1, 0, 2, 0, 0));
    tbl.push_back(idle(1, 0, 0, 0, 0, 0));
    tbl.push_back(idle(1, 1, 0, 3, 0, 0));
    tbl.push_back(idle(1, 0, 0, 0, 0, 0));
    // back-pressure: two accepts, stall, then release
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 2, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 2, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 2, 1, 0, 1, 1, 0, 2, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 3, 1, 0, 1, 1, 0, 3, 1, 0, 2, 0, 0));
    tbl.push_back(idle(1, 1, 0, 3, 0, 0));
    tbl.push_back(idle(1, 1, 0, 4, 0, 0));
    tbl.push_back(idle(1, 0, 0, 0, 0, 0));
    // read-after-write to address 5
    tbl.push_back(mk(1, 0, 5, 10, 0, 0, 0, 1, 1, 0, 1, 1, 5, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 5, 1, 0, 1, 1, 0, 5, 0, 0, 0, 0, 0));
    tbl.push_back(idle(1, 0, 0, 0, 0, 0));
    tbl.push_back(idle(1, 1, 1, 10, 0, 0));
    tbl.push_back(idle(1, 0, 0, 0, 0, 1));
    // odd number of uncontested grants must not move the pointer
    tbl.push_back(mk(1, 0, 13, 14, 0, 0, 0, 1, 1, 0, 1, 1, 13, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 12, 13, 1, 0, 0, 1, 1, 0, 1, 1, 12, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,   1, 0, 0, 1, 0, 1, 1, 0, 0,  0, 0, 0, 0, 0));
    tbl.push_back(idle(1, 0, 0, 0, 0, 0));
    tbl.push_back(idle(1, 1, 0, 1, 0, 0));
    tbl.push_back(idle(1, 0, 0, 0, 0, 0));

    // fill buffer with two words (addresses 1, 2) under back-pressure
    seq_pre.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0));
    seq_pre.push_back(mk(0, 0, 0, 0, 1, 0, 2, 0, 0, 1, 1, 0, 2, 0, 0, 0, 0, 0));
    seq_pre.push_back(idle(0, 1, 0, 2, 0, 0));
    seq_pre.push_back(idle(0, 1, 0, 2, 0, 0));
    // after reset: fresh read of address 0, no stale words
    seq_post.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    seq_post.push_back(idle(1, 0, 0, 0, 0, 0));
    seq_post.push_back(idle(1, 1, 0, 1, 0, 0));
    seq_post.push_back(idle(1, 0, 0, 0, 0, 0));
    seq_post.push_back(idle(1, 0, 0, 0, 0, 0));

    // reset state, with both requests asserted
    rst = 1'b1;
    drive(mk(1, 0, 3, 3, 1, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #12;
    chk("rst_wr_rdy", -1, 32'(wr_rdy), 0);
    chk("rst_ra_rdy", -1, 32'(ra_rdy), 0);
    chk("rst_sram_ce", -1, 32'(sram_ce), 0);
    chk("rst_rd_vld", -1, 32'(rd_vld), 0);
    chk("rst_rd_lst", -1, 32'(rd_lst), 0);
    chk("rst_rd_dat", -1, 32'(rd_dat), 0);
    chk("rst_wr_done", -1, 32'(wr_done), 0);
    chk("rst_rd_done", -1, 32'(rd_done), 0);
    @(negedge clk);
    rst = 1'b0;
    drive(idle(1, 0, 0, 0, 0, 0));

    run(tbl, 0);

    // mid-operation reset with two buffered words
    run(seq_pre, 100);
    #1;
    rst = 1'b1;
    drive(mk(1, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    chk("mid_rst_rd_vld", 104, 32'(rd_vld), 0);
    chk("mid_rst_wr_rdy", 104, 32'(wr_rdy), 0);
    chk("mid_rst_ra_rdy", 104, 32'(ra_rdy), 0);
    chk("mid_rst_sram_ce", 104, 32'(sram_ce), 0);
    @(negedge clk);
    rst = 1'b0;
    drive(idle(1, 0, 0, 0, 0, 0));
    run(seq_post, 200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
